// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: accumulates a counted stream of operands in carry-save form and resolves them to one result
module csa_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module csa_accum_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d, car_q, car_d, out_q, out_d, car_sh, psum, sco;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             take;
  assign car_sh    = {car_q[WIDTH-2:0], 1'b0};
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = out_q;
  assign take      = in_valid && in_ready;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_csa
      csa_fa u_fa (.a(sum_q[i]), .b(car_sh[i]), .c(in_data[i]), .s(psum[i]), .co(sco[i]));
    end
  endgenerate
  // next state: job load, carry-save accumulation, single-cycle resolve, result handoff
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    car_d   = car_q;
    rem_d   = rem_q;
    out_d   = out_q;
    if (state_q == IDLE && start) begin
      sum_d   = '0;
      car_d   = '0;
      rem_d   = count;
      state_d = count != '0 ? ACCUM : RESOLVE;
    end
    if (take) begin
      sum_d   = psum;
      car_d   = sco;
      rem_d   = rem_q - CNT_W'(1);
      state_d = rem_q == CNT_W'(1) ? RESOLVE : ACCUM;
    end
    if (state_q == RESOLVE) begin
      out_d   = sum_q + car_sh;
      state_d = DONE;
    end
    if (out_valid && out_ready) state_d = IDLE;
  end
  // state and datapath registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      car_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      car_q   <= car_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
    end
  end
endmodule

// File: tb/tb_csa_accum_sequencer.sv
// tb_csa_accum_sequencer: random and directed jobs checked every cycle against a job-level arithmetic model
module tb_csa_accum_sequencer;
  logic        clk = 0;
  logic        rst_n = 1;
  logic        start = 0;
  logic [7:0]  count = 0;
  logic        in_valid = 0;
  logic [31:0] in_data = 0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 0;
  logic        busy;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_result = 0;
  bit          m_busy = 0;
  bit          m_valid = 0;
  int          m_rem = 0;
  logic [31:0] m_acc = 0;
  logic [31:0] m_out = 0;

  csa_accum_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: a job is busy until its result is taken; operands are wanted while some remain;
  // once none remain the result appears one cycle later as the plain sum of all operands
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      m_busy = 0; m_valid = 0; m_rem = 0; m_acc = 0;
    end else begin
      bit exp_ready;
      exp_ready = m_busy && m_rem != 0;
      chk("busy", busy, m_busy);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("out_data", out_data, m_out);
      if (out_valid && out_ready) last_result = out_data;
      if (!m_busy) begin
        if (start) begin m_busy = 1; m_rem = count; m_acc = 0; end
      end else if (m_valid) begin
        if (out_ready) begin m_valid = 0; m_busy = 0; end
      end else if (m_rem == 0) begin
        m_valid = 1; m_out = m_acc;
      end else if (in_valid) begin
        m_acc = m_acc + in_data; m_rem--;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int cnt);
    start = 1; count = 8'(cnt); tick(); start = 0; count = 8'($urandom);
  endtask

  task automatic send(input logic [31:0] d, input int gap, input bit stray);
    for (int g = 0; g < gap; g++) begin
      in_valid = 0; in_data = $urandom;
      start = stray && $urandom_range(1) == 1; count = 8'($urandom);
      tick();
    end
    in_valid = 1; in_data = d;
    for (int k = 0; k <= 40; k++) begin
      if (k == 40) begin chk("send_timeout", 0, 1); break; end
      if (in_ready) begin tick(); break; end
      tick();
    end
    in_valid = 0; in_data = $urandom; start = 0;
  endtask

  task automatic finish_job(input int hold);
    out_ready = 0;
    for (int k = 0; k <= 20; k++) begin
      if (k == 20) begin chk("result_timeout", 0, 1); break; end
      if (out_valid) break;
      tick();
    end
    repeat (hold) tick();
    out_ready = 1; tick(); out_ready = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    repeat (3) tick();
    rst_n = 1; tick();
    start_job(3);
    send(5, 0, 0); send(7, 0, 0); send(9, 0, 0);
    finish_job(0);
    chk("basic_21", last_result, 21);
    start_job(2);
    send(32'hFFFF_FFFF, 0, 0); send(32'h0000_0003, 0, 0);
    finish_job(1);
    chk("wrap", last_result, 32'h0000_0002);
    last_result = 32'hDEAD_BEEF;
    start_job(0);
    finish_job(0);
    chk("empty", last_result, 0);
    start_job(4);
    send(1, 1, 1); send(2, 2, 1); send(3, 0, 1); send(4, 3, 1);
    finish_job(5);
    chk("backpressure", last_result, 10);
    start_job(5);
    send(11, 0, 0); send(13, 0, 0);
    rst_n = 0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    tick(); tick(); rst_n = 1; tick();
    start_job(1);
    send(42, 0, 0);
    finish_job(2);
    chk("after_reset", last_result, 42);
    start_job(255);
    for (int n = 0; n < 255; n++) send(32'h0101_0101, 0, 0);
    finish_job(0);
    chk("long", last_result, 32'hFFFF_FFFF);
    for (int j = 0; j < 40; j++) begin
      int cnt;
      cnt = $urandom_range(9);
      start_job(cnt);
      for (int n = 0; n < cnt; n++) send($urandom, $urandom_range(2), 1);
      finish_job($urandom_range(3));
      repeat ($urandom_range(2)) tick();
    end
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
